// File: rtl/qam16_pkg.sv
// qam16_pkg: shared constants and types for the 16-QAM demodulator.
// Holds the carrier reference tables, the Gray level map, the accumulator
// width helper and the FSM state type.
package qam16_pkg;

  localparam int LUT_N    = 16;
  localparam int LUT_BITS = 8;

  typedef logic signed [LUT_BITS-1:0] lut_t;

  // round(127*cos(2*pi*n/16)) and round(127*sin(2*pi*n/16))
  localparam lut_t COS_LUT [LUT_N] = '{
    8'sd127,  8'sd117,  8'sd90,   8'sd49,
    8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
   -8'sd127, -8'sd117, -8'sd90,  -8'sd49,
    8'sd0,    8'sd49,   8'sd90,   8'sd117
  };

  localparam lut_t SIN_LUT [LUT_N] = '{
    8'sd0,    8'sd49,   8'sd90,   8'sd117,
    8'sd127,  8'sd117,  8'sd90,   8'sd49,
    8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
   -8'sd127, -8'sd117, -8'sd90,  -8'sd49
  };

  // Gray code per amplitude level
  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  // Full-precision integrator width: product width plus growth over a symbol
  function automatic int acc_width(input int in_w, input int lut_w, input int sps);
    return in_w + lut_w + $clog2(sps);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/qam16_slicer.sv
// qam16_slicer: maps one integrated I or Q sum onto its 2-bit Gray code.
// Inner/outer boundary sits at +/-thresh, the sign boundary at zero.
module qam16_slicer
  import qam16_pkg::*;
#(
  parameter int ACC_W = 21
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] thresh,
  output logic        [1:0]       bits
);

  logic signed [ACC_W-1:0] neg_thresh;

  // four-way decision, -thresh belongs to the outer level, zero to the inner
  always_comb begin
    neg_thresh = -thresh;
    if (acc <= neg_thresh) begin
      bits = GRAY_M3;
    end else if (acc[ACC_W-1]) begin
      bits = GRAY_M1;
    end else if (acc < thresh) begin
      bits = GRAY_P1;
    end else begin
      bits = GRAY_P3;
    end
  end

endmodule

// File: rtl/qam16_demod.sv
// qam16_demod: coherent 16-QAM demodulator.
// Mixes passband samples with cos/-sin references, integrates over one
// symbol, slices I/Q to Gray bits and re-serialises them MSB first.
// Optional macro QAM16_DEMOD_SYMOUT_EN adds the parallel sym_out/sym_valid
// ports. The reference tables hold 16 points, so SPS may be 4, 8 or 16.
//
// state | meaning
// IDLE  | waiting for a valid sample qualified by sym_sync
// RUN   | integrating; phase counts samples inside the current symbol
module qam16_demod
  import qam16_pkg::*;
#(
  parameter int SPS    = 16,
  parameter int IN_W   = 9,
  parameter int LUT_W  = 8,
  parameter int THRESH = 64516
) (
  input  logic                   carrier_clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] signal,
  input  logic                   in_valid,
  input  logic                   sym_sync,
  output logic                   out_data,
  output logic                   out_strobe,
  output logic                   locked
`ifdef QAM16_DEMOD_SYMOUT_EN
  ,
  output logic [3:0]             sym_out,
  output logic                   sym_valid
`endif
);

  localparam int ACC_W    = acc_width(IN_W, LUT_W, SPS);
  localparam int PROD_W   = IN_W + LUT_W;
  localparam int PH_W     = $clog2(SPS);
  localparam int LUT_STEP = LUT_N / SPS;
  localparam int QTR      = SPS / 4;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
  logic [3:0]              sreg_q, sreg_d;
  logic [2:0]              pend_q, pend_d;
  logic                    out_data_q, out_data_d;
  logic                    out_strobe_q, out_strobe_d;
  logic                    locked_q, locked_d;
`ifdef QAM16_DEMOD_SYMOUT_EN
  logic [3:0]              sym_out_q, sym_out_d;
  logic                    sym_valid_q, sym_valid_d;
`endif

  logic                    restart;
  logic [PH_W-1:0]         ph_eff;
  logic [3:0]              lut_idx;
  logic signed [LUT_W-1:0] cos_v, sin_v;
  logic signed [PROD_W-1:0] p_i, p_q;
  logic signed [ACC_W-1:0] base_i, base_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] thresh_s;
  logic [1:0]              bits_i, bits_q;
  logic                    sym_end;
  logic                    out_point;

  assign thresh_s = ACC_W'(THRESH);

  // mixer and running sums; a (re)sync sample is treated as phase 0 of a fresh symbol
  always_comb begin
    restart   = in_valid && sym_sync && ((state_q == IDLE) || (phase_q != '0));
    ph_eff    = restart ? '0 : phase_q;
    lut_idx   = 4'(int'(ph_eff) * LUT_STEP);
    cos_v     = LUT_W'(COS_LUT[lut_idx]);
    sin_v     = LUT_W'(SIN_LUT[lut_idx]);
    p_i       = PROD_W'(signal) * PROD_W'(cos_v);
    p_q       = -(PROD_W'(signal) * PROD_W'(sin_v));
    base_i    = restart ? '0 : acc_i_q;
    base_q    = restart ? '0 : acc_q_q;
    sum_i     = base_i + ACC_W'(p_i);
    sum_q     = base_q + ACC_W'(p_q);
    sym_end   = in_valid && !restart && (state_q == RUN) && (phase_q == PH_W'(SPS - 1));
    out_point = (int'(phase_q) % QTR) == 0;
  end

  qam16_slicer #(.ACC_W(ACC_W)) u_slice_i (
    .acc    (sum_i),
    .thresh (thresh_s),
    .bits   (bits_i)
  );

  qam16_slicer #(.ACC_W(ACC_W)) u_slice_q (
    .acc    (sum_q),
    .thresh (thresh_s),
    .bits   (bits_q)
  );

  // next-state: sync handling, integration, symbol load and bit serialisation
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    sreg_d       = sreg_q;
    pend_d       = pend_q;
    out_data_d   = out_data_q;
    out_strobe_d = 1'b0;
    locked_d     = locked_q;
`ifdef QAM16_DEMOD_SYMOUT_EN
    sym_out_d    = sym_out_q;
    sym_valid_d  = 1'b0;
`endif
    if (restart) begin
      state_d  = RUN;
      phase_d  = PH_W'(1);
      acc_i_d  = sum_i;
      acc_q_d  = sum_q;
      sreg_d   = '0;
      pend_d   = '0;
      locked_d = 1'b0;
    end else if (in_valid && (state_q == RUN)) begin
      // previous symbol's bits go out before a new symbol may overwrite the register
      if (out_point && (pend_q != '0)) begin
        out_data_d   = sreg_q[3];
        out_strobe_d = 1'b1;
        sreg_d       = {sreg_q[2:0], 1'b0};
        pend_d       = pend_q - 3'd1;
      end
      if (sym_end) begin
        sreg_d   = {bits_i, bits_q};
        pend_d   = 3'd4;
        locked_d = 1'b1;
        acc_i_d  = '0;
        acc_q_d  = '0;
        phase_d  = '0;
`ifdef QAM16_DEMOD_SYMOUT_EN
        sym_out_d   = {bits_i, bits_q};
        sym_valid_d = 1'b1;
`endif
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  // state register with synchronous reset
  always_ff @(posedge carrier_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      sreg_q       <= '0;
      pend_q       <= '0;
      out_data_q   <= 1'b0;
      out_strobe_q <= 1'b0;
      locked_q     <= 1'b0;
`ifdef QAM16_DEMOD_SYMOUT_EN
      sym_out_q    <= '0;
      sym_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      sreg_q       <= sreg_d;
      pend_q       <= pend_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      locked_q     <= locked_d;
`ifdef QAM16_DEMOD_SYMOUT_EN
      sym_out_q    <= sym_out_d;
      sym_valid_q  <= sym_valid_d;
`endif
    end
  end

  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign locked     = locked_q;
`ifdef QAM16_DEMOD_SYMOUT_EN
  assign sym_out    = sym_out_q;
  assign sym_valid  = sym_valid_q;
`endif

endmodule

// File: doc/qam16_demod.md
Name: qam16_demod

Overview:
- Coherent 16-QAM demodulator; receive-side counterpart of mod_16QAM.
- Takes signed 9-bit passband samples (same format as mod_out) at the carrier rate.
- Mixes the samples against internal cos/sin references and integrates over one symbol.
- Slices I/Q to Gray-coded 4-bit symbols and re-serialises them onto out_data with a bit strobe.

Parameters:
- SPS, 16: samples per symbol, one carrier period per symbol. Power of 2, >=4, multiple of 4.
- IN_W, 9: input sample width, signed.
- LUT_W, 8: reference cos/sin width, signed, amplitude 127.
- THRESH, 64516: inner/outer decision threshold on |accumulator|, equal to 2x the unit-level integral.

Ports:
- carrier_clk  in  1  sole clock, one sample per cycle when in_valid.
- reset  in  1  synchronous, active-high.
- signal  in  IN_W  signed passband sample.
- in_valid  in  1  sample qualifier.
- sym_sync  in  1  high with the valid sample that is phase 0 of a symbol.
- out_data  out  1  recovered serial bit, held between strobes.
- out_strobe  out  1  one-cycle pulse when out_data updates.
- locked  out  1  high once the first full symbol has been decided after sync.

Behaviour:
- Reset values: out_data=0, out_strobe=0, locked=0. Internally: phase=0, I_acc=Q_acc=0, shift register=0, FSM=IDLE.
- Reset mid-operation: all state returns to the reset values on the next edge. No partial output is emitted.
- FSM IDLE:
  - Ignores samples until in_valid & sym_sync.
  - On that sample: phase<-1, I_acc<-p_I, Q_acc<-p_Q, go to RUN.
- FSM RUN, on each in_valid:
  - p_I = signal*COS[phase]; p_Q = -(signal*SIN[phase]).
  - Accumulate both; phase wraps SPS-1 -> 0.
  - in_valid low: everything holds, no strobe.
- Widths: products are IN_W+LUT_W bits. ACC_W = IN_W+LUT_W+log2(SPS) = 21, signed, full precision, no saturation.
- Symbol end (sample at phase SPS-1): slice the final sums (including that sample).
  - acc <= -THRESH -> 00
  - -THRESH < acc < 0 -> 01
  - 0 <= acc < THRESH -> 11
  - acc >= THRESH -> 10
  - Symbol = {I1,I0,Q1,Q0}, loaded into the 4-bit shift register.
  - Accumulators restart from the phase-0 products of the next sample.
  - locked<-1 on the first load.
- Serialisation:
  - Bit k (MSB first, k=0..3) is driven on out_data with out_strobe=1 one cycle after the valid sample at phase k*SPS/4 of the following symbol.
  - Bit 0 therefore appears 1 cycle after the first sample of the next symbol.
  - End-to-end symbol latency: SPS samples plus 1 cycle.
- sym_sync in RUN at phase 0: no effect (confirms alignment).
- sym_sync in RUN at phase != 0 (realign):
  - Discard the partial accumulators; restart as from IDLE with this sample.
  - Clear the pending shift register, suppress its remaining strobes, locked<-0.
- No sym_sync ever: stay in IDLE, outputs remain at reset values.

Optional Feature:
- Macro QAM16_DEMOD_SYMOUT_EN.
- Defined: adds ports sym_out[3:0] and sym_valid. sym_valid pulses one cycle after the phase SPS-1 sample, with sym_out carrying the sliced symbol (same value loaded into the shift register).
- Undefined: ports absent, behaviour otherwise identical.

Decomposition:
- Package qam16_pkg holds:
  - COS/SIN LUT constants: 16 entries, round(127*cos/sin(2*pi*n/16)).
  - Gray level map constants (00,01,11,10 for -3,-1,+1,+3).
  - ACC_W function/constant.
  - FSM state enum {IDLE,RUN}.
- One combinational sub-module qam16_slicer: ACC_W signed sum plus THRESH in, 2 Gray bits out; instantiated twice (I, Q).

Test Plan:
1. Reset held 5 cycles with random samples -> out_data=0, out_strobe=0, locked=0 throughout.
2. Modulate I=+3,Q=-1, samples=(lvlI*COS[n]-lvlQ*SIN[n])>>>2, sym_sync on n=0 -> locked=1 after 16 samples; bits 1,0,0,1 with strobes at cycles 1,5,9,13 of next symbol.
3. All 16 symbols back-to-back -> recovered serial stream equals transmitted {I1,I0,Q1,Q0} stream bit-exact after 1-symbol latency.
4. in_valid low for 3 cycles mid-symbol -> decisions unchanged, strobe spacing stretched by 3 cycles, no extra strobes.
5. sym_sync asserted at phase 7 -> pending bits dropped, locked=0, next symbol decided correctly 16 samples later.
6. Boundary: input scaled so I_acc=THRESH exactly -> I bits 10; I_acc=THRESH-1 -> 11; I_acc=0 -> 11.
